// File: rtl/ksa_sub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ksa_sub_pkg
// Shared definitions for the pipelined Kogge-Stone subtractor.
//   W_DEF       : default operand width (23 bits)
//   LEVELS      : number of prefix rows, ceil(log2(W_DEF))
//   gp_t        : generate/propagate vector pair carried between prefix rows
//   prefix_dist : lookback distance of a given prefix row (0-based)
// ---------------------------------------------------------------------------
package ksa_sub_pkg;

    localparam int W_DEF  = 23;
    localparam int LEVELS = 5;

    typedef struct packed {
        logic [W_DEF-1:0] g;
        logic [W_DEF-1:0] p;
    } gp_t;

    // Row lvl combines each bit with the bit 2**lvl positions below it.
    function automatic int prefix_dist(input int lvl);
        return 1 << lvl;
    endfunction

endpackage

// File: rtl/ksa_sub_pipe_if.sv
// ---------------------------------------------------------------------------
// ksa_sub_pipe_if
// Operand stream in, result stream out, for the pipelined subtractor.
//   in_valid/in_ready   : operand beat handshake
//   X, Y, Bin           : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result beat handshake
//   D, Bout, V          : difference, borrow-out, signed overflow
// master = producer of operands / consumer of results (e.g. a bench)
// slave  = the subtractor itself
// ---------------------------------------------------------------------------
interface ksa_sub_pipe_if
    import ksa_sub_pkg::*;
#(
    parameter int W = W_DEF
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         V;

    modport master (
        output in_valid, X, Y, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, V
    );

    modport slave (
        input  in_valid, X, Y, Bin, out_ready,
        output in_ready, out_valid, D, Bout, V
    );

endinterface

// File: rtl/ksa_sub_pipe_prefix_level.sv
// ---------------------------------------------------------------------------
// ksa_prefix_level
// One purely combinational Kogge-Stone row. Each bit i >= DIST merges its
// (g,p) pair with the pair DIST positions below; lower bits already hold
// their final group value and pass straight through.
//   g_in, p_in   : generate/propagate from the previous row
//   g_out, p_out : generate/propagate after this row
// ---------------------------------------------------------------------------
module ksa_prefix_level #(
    parameter int W    = 23,
    parameter int DIST = 1
) (
    input  logic [W-1:0] g_in,
    input  logic [W-1:0] p_in,
    output logic [W-1:0] g_out,
    output logic [W-1:0] p_out
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i < DIST) begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end else begin : g_merge
            // (G,P) o (G',P') = (G | P&G', P&P')
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
            assign p_out[i] = p_in[i] & p_in[i-DIST];
        end
    end

endmodule

// File: rtl/ksa_sub_pipe.sv
// ---------------------------------------------------------------------------
// ksa_sub_pipe
// Pipelined two's-complement subtractor D = X - Y - Bin (mod 2**W), built as
// a Kogge-Stone adder on X + ~Y + ~Bin. Three register stages give a fixed
// latency of three accepting edges:
//   S1 : bitwise G0/P0, carry-in, operand sign bits
//   S2 : prefix result after rows 1-2, plus P0, carry-in and sign bits
//   S3 : D, Bout, V
// All stages advance together whenever the output slot is free or being
// drained; bubbles are kept rather than squeezed out.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset, clears all stages
//   bus : ksa_sub_pipe_if slave (operand and result streams)
// ---------------------------------------------------------------------------
module ksa_sub_pipe
    import ksa_sub_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    ksa_sub_pipe_if.slave bus
);

    // Prefix row outputs; index 0 is the S1 register, index k the output of row k.
    gp_t lvl_gp [0:LEVELS];

    gp_t          s1_gp;
    logic         s1_cin;
    logic         s1_xs;
    logic         s1_ys;
    logic         v1;

    gp_t          s2_gp;
    logic [W-1:0] s2_p0;
    logic         s2_cin;
    logic         s2_xs;
    logic         s2_ys;
    logic         v2;

    logic [W-1:0] d3;
    logic         bout3;
    logic         ovf3;
    logic         v3;

    logic         adv;
    logic [W-1:0] y_inv;
    logic [W-1:0] g_fin;
    logic [W-1:0] p_fin;
    logic [W-1:0] carry;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    // The whole pipe moves only when the result slot is empty or being taken.
    assign adv          = ~v3 | bus.out_ready;
    assign bus.in_ready = adv & ~RST;

    assign y_inv     = ~bus.Y;
    assign lvl_gp[0] = s1_gp;

    // Rows 1-2 feed the S2 register; rows 3-5 start again from the S2 copy.
    for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
        gp_t row_in;
        if (lvl == 2) begin : g_cut
            assign row_in = s2_gp;
        end else begin : g_chain
            assign row_in = lvl_gp[lvl];
        end
        ksa_prefix_level #(
            .W    (W),
            .DIST (prefix_dist(lvl))
        ) u_level (
            .g_in  (row_in.g),
            .p_in  (row_in.p),
            .g_out (lvl_gp[lvl+1].g),
            .p_out (lvl_gp[lvl+1].p)
        );
    end

    assign g_fin  = lvl_gp[LEVELS].g;
    assign p_fin  = lvl_gp[LEVELS].p;
    // Carry into bit i is the group carry of bits i-1..0 with the injected carry-in.
    assign carry  = {g_fin[W-2:0] | (p_fin[W-2:0] & {(W-1){s2_cin}}), s2_cin};
    assign diff   = s2_p0 ^ carry;
    assign borrow = ~(g_fin[W-1] | (p_fin[W-1] & s2_cin));
    assign ovf    = (s2_xs ^ s2_ys) & (s2_xs ^ diff[W-1]);

    // Stage registers and valid bits. Reset clears everything, so in-flight
    // beats vanish and the result outputs read zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_gp  <= '0;
            s1_cin <= 1'b0;
            s1_xs  <= 1'b0;
            s1_ys  <= 1'b0;
            v1     <= 1'b0;
            s2_gp  <= '0;
            s2_p0  <= '0;
            s2_cin <= 1'b0;
            s2_xs  <= 1'b0;
            s2_ys  <= 1'b0;
            v2     <= 1'b0;
            d3     <= '0;
            bout3  <= 1'b0;
            ovf3   <= 1'b0;
            v3     <= 1'b0;
        end else if (adv) begin
            s1_gp.g <= bus.X & y_inv;
            s1_gp.p <= bus.X ^ y_inv;
            s1_cin  <= ~bus.Bin;
            s1_xs   <= bus.X[W-1];
            s1_ys   <= bus.Y[W-1];
            v1      <= bus.in_valid;

            s2_gp  <= lvl_gp[2];
            s2_p0  <= s1_gp.p;
            s2_cin <= s1_cin;
            s2_xs  <= s1_xs;
            s2_ys  <= s1_ys;
            v2     <= v1;

            d3    <= diff;
            bout3 <= borrow;
            ovf3  <= ovf;
            v3    <= v2;
        end
    end

    assign bus.out_valid = v3;
    assign bus.D         = d3;
    assign bus.Bout      = bout3;
    assign bus.V         = ovf3;

endmodule
